// File: rtl/sysbus_mem_ctrl.sv
// SysBus-to-asynchronous-SRAM access controller: latches address/write data from SysBus,
// runs one strobed SRAM cycle with programmable wait states and returns read data with a Done pulse.
module sysbus_mem_ctrl #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] RESET_DATA  = 16'h0000
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic        Write,
  input  logic [15:0] SysBusIn,
  output logic [15:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Overrun,
  output logic [15:0] RamAddr,
  output logic [15:0] RamWData,
  input  logic [15:0] RamRData,
  output logic        RamCe_n,
  output logic        RamOe_n,
  output logic        RamWe_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;
  logic        ovr_q, ovr_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = Write ? S_WDATA : S_SETUP;
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: if (cnt_q == 4'd0) state_d = S_HOLD;
      S_HOLD:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter, read-data return and sticky overrun flag
  always_comb begin
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d = SysBusIn;
          wr_d   = Write;
        end
      end
      S_WDATA:  wdata_d = SysBusIn;
      S_SETUP:  cnt_d = 4'(WAIT_STATES);
      S_STROBE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!wr_q) begin
          data_d = RamRData;
        end
      end
      default: ;
    endcase
    if (Start && (state_q != S_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wr_q    <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      data_q  <= RESET_DATA;
      ovr_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  // Strobes decode from registered state only so they cannot glitch on input changes
  always_comb begin
    Busy     = (state_q != S_IDLE);
    Done     = (state_q == S_DONE);
    RamCe_n  = !((state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD));
    RamOe_n  = !((state_q == S_STROBE) && !wr_q);
    RamWe_n  = !((state_q == S_STROBE) && wr_q);
    DataIn   = data_q;
    Overrun  = ovr_q;
    RamAddr  = addr_q;
    RamWData = wdata_q;
  end

endmodule

// File: tb/tb_sysbus_mem_ctrl.sv
// Scoreboard bench for sysbus_mem_ctrl: one instance with WAIT_STATES=2 and one with WAIT_STATES=0.
module tb_sysbus_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start   [2];
  logic        write   [2];
  logic [15:0] sysbus  [2];
  logic [15:0] rdata   [2];
  logic [15:0] data_in [2];
  logic [15:0] ram_addr[2];
  logic [15:0] ram_wd  [2];
  logic        busy    [2];
  logic        done    [2];
  logic        ovr     [2];
  logic        ce_n    [2];
  logic        oe_n    [2];
  logic        we_n    [2];

  typedef struct {
    int          dev;
    logic [15:0] dout;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    int          oe;
    int          we;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] last_rd [2];
  logic [15:0] last_wd [2];
  logic        exp_ovr [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WS = (g == 0) ? 2 : 0;

    sysbus_mem_ctrl #(.WAIT_STATES(WS), .RESET_DATA(16'h0000)) u_dut (
      .Clock   (clk),
      .nReset  (rst_n),
      .Start   (start[g]),
      .Write   (write[g]),
      .SysBusIn(sysbus[g]),
      .DataIn  (data_in[g]),
      .Busy    (busy[g]),
      .Done    (done[g]),
      .Overrun (ovr[g]),
      .RamAddr (ram_addr[g]),
      .RamWData(ram_wd[g]),
      .RamRData(rdata[g]),
      .RamCe_n (ce_n[g]),
      .RamOe_n (oe_n[g]),
      .RamWe_n (we_n[g])
    );

    int   cnt, oec, wec;
    logic act, viol;
    exp_t e;

    always @(negedge clk) begin
      if (!rst_n) begin
        act = 1'b0; cnt = 0; oec = 0; wec = 0; viol = 1'b0;
      end else begin
        if (busy[g] && !act) begin
          act = 1'b1; cnt = 0; oec = 0; wec = 0; viol = 1'b0;
        end
        if (act) begin
          cnt++;
          if (!oe_n[g]) oec++;
          if (!we_n[g]) wec++;
        end
        if ((!oe_n[g] && !we_n[g]) || (ce_n[g] && (!oe_n[g] || !we_n[g]))) viol = 1'b1;
        if (done[g]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dev%0d: got done with empty queue, required none", g);
          end else begin
            e = sb.pop_front();
            chk("dev", g, e.dev);
            chk("data_in", data_in[g], e.dout);
            chk("ram_addr", ram_addr[g], e.addr);
            chk("ram_wdata", ram_wd[g], e.wdata);
            chk("latency", cnt, e.lat);
            chk("oe_cycles", oec, e.oe);
            chk("we_cycles", wec, e.we);
            chk("overrun", ovr[g], e.ovr);
            chk("strobe_rules", viol, 1'b0);
            chk("ce_at_done", ce_n[g], 1'b1);
          end
          act = 1'b0;
        end
      end
    end
  end

  task automatic access(input int d, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] rd, input logic push);
    exp_t e;
    int   ws;
    ws = (d == 0) ? 2 : 0;
    @(posedge clk); #1;
    start[d] = 1'b1; write[d] = wr; sysbus[d] = addr; rdata[d] = rd;
    if (push) begin
      if (!wr) last_rd[d] = rd;
      if (wr) last_wd[d] = wd;
      e.dev   = d;
      e.dout  = last_rd[d];
      e.addr  = addr;
      e.wdata = last_wd[d];
      e.lat   = (wr ? 5 : 4) + ws;
      e.oe    = wr ? 0 : ws + 1;
      e.we    = wr ? ws + 1 : 0;
      e.ovr   = exp_ovr[d];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start[d] = 1'b0; write[d] = 1'b0; sysbus[d] = wd;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[d] && n < 50);
    chk("done_timeout", done[d], 1'b1);
  endtask

  task automatic check_reset_state(input int d);
    chk("rst_data_in", data_in[d], 16'h0000);
    chk("rst_ram_addr", ram_addr[d], 16'h0000);
    chk("rst_ram_wdata", ram_wd[d], 16'h0000);
    chk("rst_busy_done_ovr", {busy[d], done[d], ovr[d]}, 3'b000);
    chk("rst_strobes", {ce_n[d], oe_n[d], we_n[d]}, 3'b111);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; write[i] = 1'b0; sysbus[i] = 16'h0; rdata[i] = 16'h0;
      last_rd[i] = 16'h0; last_wd[i] = 16'h0; exp_ovr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) check_reset_state(i);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // WAIT_STATES=2 read and write
    access(0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b1);
    wait_done(0);
    access(0, 1'b1, 16'h1234, 16'hA5A5, 16'h5555, 1'b1);
    wait_done(0);

    // WAIT_STATES=0 boundary read/write
    access(1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1'b1);
    wait_done(1);
    access(1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b1);
    wait_done(1);

    // Start while busy sets sticky Overrun; first access unaffected
    chk("ovr_before", ovr[0], 1'b0);
    exp_ovr[0] = 1'b1;
    access(0, 1'b0, 16'h0100, 16'h0000, 16'h1111, 1'b1);
    @(posedge clk); #1;
    start[0] = 1'b1; write[0] = 1'b1; sysbus[0] = 16'h0200;
    @(posedge clk); #1;
    start[0] = 1'b0; write[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("ovr_sticky", ovr[0], 1'b1);
    chk("busy_after_ignored_start", busy[0], 1'b0);

    // Back-to-back reads, second Start in the cycle after Done
    access(0, 1'b0, 16'h0300, 16'h0000, 16'h2222, 1'b1);
    wait_done(0);
    access(0, 1'b0, 16'h0301, 16'h0000, 16'h3333, 1'b1);
    wait_done(0);

    // Reset in the middle of a strobe aborts immediately
    access(0, 1'b0, 16'h0500, 16'h0000, 16'h7777, 1'b0);
    begin
      int n;
      n = 0;
      while (oe_n[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("reach_strobe", oe_n[0], 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_data_in", data_in[0], 16'h0000);
    chk("abort_ovr", ovr[0], 1'b0);
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 16'h0; last_wd[i] = 16'h0; exp_ovr[i] = 1'b0;
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", busy[0], 1'b0);
    access(0, 1'b0, 16'h0600, 16'h0000, 16'h4444, 1'b1);
    wait_done(0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
